// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   - parity mode encodings used by the PARITY parameter
//   - transmit FSM state encoding
//   - idle (mark) level of the serial line
//   - parity helper that turns the XOR of the data bits into the line value
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Line is held at mark between frames and during reset.
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Even parity sends the XOR of the data bits so the total count of ones
  // (data + parity) is even; odd parity sends its inverse.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
// Occupancy is kept in a separate counter so full and empty are never
// ambiguous; pointers wrap naturally because DEPTH is a power of two.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset; flushes the FIFO
//   push       write push_data (ignored when full)
//   push_data  word to store
//   pop        discard the head word (ignored when empty)
//   pop_data   head word, valid while empty is low
//   count      number of stored words, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: reset only clears the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Buffered, parametrised UART transmitter.
// Words arrive over a valid/ready handshake into uart_tx_fifo and are sent
// LSB-first as: start bit, DATA_BITS data bits, optional parity bit,
// STOP_BITS stop bits, each bit lasting CLKS_PER_BIT clocks. A frame whose
// last stop cycle finds another word queued goes straight into the next
// start bit, so back-to-back frames have no idle gap.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset; abandons any frame
//   uart_tx_valid  input word valid
//   uart_tx_input  word to send
//   uart_tx_ready  FIFO can accept a word (registered occupancy < depth)
//   uart_txd       registered serial output, idle high
//   uart_tx_busy   frame in progress or words queued
//   uart_tx_count  FIFO occupancy
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line at mark, waiting for a queued word
// ST_START  | driving the start bit (0)
// ST_DATA   | driving data bits, LSB first, shifting once per bit
// ST_PARITY | driving the parity bit (only when PARITY != none)
// ST_STOP   | driving stop bit(s); last cycle may pop the next word
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_tx_valid,
  input  logic [DATA_BITS-1:0]          uart_tx_input,
  output logic                          uart_tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   uart_tx_count
);

  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam int DCW = $clog2(DATA_BITS + 1);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  // Both counters are down-counters that finish at zero, so they are
  // loaded with (period - 1) and never need to hold the full period.
  localparam logic [BCW-1:0] BAUD_LOAD = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BAUD_ONE  = BCW'(1);
  localparam logic [DCW-1:0] DATA_LOAD = DCW'(DATA_BITS - 1);
  localparam logic [DCW-1:0] STOP_LOAD = DCW'(STOP_BITS - 1);
  localparam logic [DCW-1:0] BIT_ONE   = DCW'(1);
  localparam logic           HAS_PARITY = (PARITY != PARITY_NONE);

  tx_state_t              state;
  logic [BCW-1:0]         baud_cnt;
  logic [DCW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_bit;
  logic                   txd_q;

  logic [DATA_BITS-1:0]   fifo_data;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   baud_tc;
  logic                   bit_last;
  logic                   frame_done;

  assign baud_tc    = (baud_cnt == '0);
  assign bit_last   = (bit_cnt == '0);
  assign frame_done = (state == ST_STOP) && baud_tc && bit_last;

  // Ready comes from the registered count only; a pop on the same edge
  // does not open a slot for a push while full.
  assign uart_tx_ready = !fifo_full;
  assign fifo_push     = uart_tx_valid && uart_tx_ready;
  assign fifo_pop      = !fifo_empty && ((state == ST_IDLE) || frame_done);

  assign uart_txd      = txd_q;
  assign uart_tx_count = fifo_count;
  assign uart_tx_busy  = (state != ST_IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (uart_tx_input),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      txd_q    <= LINE_IDLE;
    end else if (fifo_pop) begin
      // Covers both a fresh start from idle and the seamless hand-over
      // on the last stop cycle.
      shift    <= fifo_data;
      par_bit  <= parity_bit(^fifo_data, PARITY);
      baud_cnt <= BAUD_LOAD;
      state    <= ST_START;
      txd_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          txd_q <= LINE_IDLE;
        end

        ST_START: begin
          if (baud_tc) begin
            baud_cnt <= BAUD_LOAD;
            bit_cnt  <= DATA_LOAD;
            txd_q    <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end

        ST_DATA: begin
          if (baud_tc) begin
            baud_cnt <= BAUD_LOAD;
            if (!bit_last) begin
              // The line is registered, so it takes the bit that becomes
              // shift[0] after this shift.
              bit_cnt <= bit_cnt - BIT_ONE;
              shift   <= shift >> 1;
              txd_q   <= shift[1];
            end else if (HAS_PARITY) begin
              txd_q <= par_bit;
              state <= ST_PARITY;
            end else begin
              bit_cnt <= STOP_LOAD;
              txd_q   <= LINE_IDLE;
              state   <= ST_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end

        ST_PARITY: begin
          if (baud_tc) begin
            baud_cnt <= BAUD_LOAD;
            bit_cnt  <= STOP_LOAD;
            txd_q    <= LINE_IDLE;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end

        ST_STOP: begin
          if (baud_tc) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_last) begin
              state <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt - BIT_ONE;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end

        default: begin
          txd_q <= LINE_IDLE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

  localparam int NI = 5;
  // instance: 0=8N1/4, 1=8E1/4, 2=8O1/4, 3=7N2/4, 4=9N1/2
  localparam int P_CPB [NI] = '{4, 4, 4, 4, 2};
  localparam int P_DB  [NI] = '{8, 8, 8, 7, 9};
  localparam int P_PAR [NI] = '{0, 2, 1, 0, 0};
  localparam int P_SB  [NI] = '{1, 1, 1, 2, 1};
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid [NI];
  logic [8:0] din   [NI];
  logic       txd   [NI];
  logic       rdy   [NI];
  logic       busy  [NI];
  logic [2:0] cnt   [NI];

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .reset(rst_n), .uart_tx_valid(valid[0]), .uart_tx_input(din[0][7:0]),
    .uart_tx_ready(rdy[0]), .uart_txd(txd[0]), .uart_tx_busy(busy[0]), .uart_tx_count(cnt[0]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .reset(rst_n), .uart_tx_valid(valid[1]), .uart_tx_input(din[1][7:0]),
    .uart_tx_ready(rdy[1]), .uart_txd(txd[1]), .uart_tx_busy(busy[1]), .uart_tx_count(cnt[1]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .reset(rst_n), .uart_tx_valid(valid[2]), .uart_tx_input(din[2][7:0]),
    .uart_tx_ready(rdy[2]), .uart_txd(txd[2]), .uart_tx_busy(busy[2]), .uart_tx_count(cnt[2]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .reset(rst_n), .uart_tx_valid(valid[3]), .uart_tx_input(din[3][6:0]),
    .uart_tx_ready(rdy[3]), .uart_txd(txd[3]), .uart_tx_busy(busy[3]), .uart_tx_count(cnt[3]));
  uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_9n1 (
    .clk(clk), .reset(rst_n), .uart_tx_valid(valid[4]), .uart_tx_input(din[4]),
    .uart_tx_ready(rdy[4]), .uart_txd(txd[4]), .uart_tx_busy(busy[4]), .uart_tx_count(cnt[4]));

  // ---------------- reference model: frame schedule per instance ----------------
  typedef struct {
    int         start;
    logic [8:0] word;
  } frame_t;

  frame_t fq [NI][$];
  int     last_end [NI];
  int     mcnt [NI];
  bit     acc [NI];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  function automatic int flen(input int i);
    return P_CPB[i] * (1 + P_DB[i] + ((P_PAR[i] != 0) ? 1 : 0) + P_SB[i]);
  endfunction

  // Line level of bit slot k of a frame carrying word w.
  function automatic int exp_bit(input int i, input logic [8:0] w, input int k);
    int ones;
    if (k == 0) return 0;
    if (k <= P_DB[i]) return int'(w[k-1]);
    if (P_PAR[i] != 0 && k == P_DB[i] + 1) begin
      ones = $countones(w);
      return (P_PAR[i] == 2) ? (ones % 2) : (1 - ones % 2);
    end
    return 1;
  endfunction

  task automatic check(input string name, input int inst, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, inst, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      fq[i].delete();
      last_end[i] = 0;
      mcnt[i] = 0;
      acc[i] = 1'b0;
    end
  endtask

  // One rising edge: a push is accepted when the pre-edge occupancy is below
  // the depth; its frame starts one edge later, or right where the previous
  // frame ends, whichever is later.
  task automatic model_edge();
    logic [8:0] mask;
    int s;
    for (int i = 0; i < NI; i++) begin
      while (fq[i].size() > 0 && fq[i][0].start + flen(i) <= cyc) void'(fq[i].pop_front());
      acc[i] = 1'b0;
      if (valid[i] && mcnt[i] < DEPTH) begin
        mask = (9'h1 << P_DB[i]) - 9'h1;
        s = (cyc + 1 > last_end[i]) ? cyc + 1 : last_end[i];
        fq[i].push_back('{start: s, word: din[i] & mask});
        last_end[i] = s + flen(i);
        acc[i] = 1'b1;
      end
      mcnt[i] = 0;
      foreach (fq[i][j]) if (fq[i][j].start > cyc) mcnt[i]++;
    end
  endtask

  task automatic check_all();
    int e;
    for (int i = 0; i < NI; i++) begin
      e = 1;
      if (fq[i].size() > 0 && fq[i][0].start <= cyc)
        e = exp_bit(i, fq[i][0].word, (cyc - fq[i][0].start) / P_CPB[i]);
      check("txd", i, int'(txd[i]), e);
      check("busy", i, int'(busy[i]), (cyc < last_end[i]) ? 1 : 0);
      check("count", i, int'(cnt[i]), mcnt[i]);
      check("ready", i, int'(rdy[i]), (mcnt[i] < DEPTH) ? 1 : 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      model_edge();
    end
    @(negedge clk);
    if (rst_n) check_all();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++) if (last_end[i] > cyc || fq[i].size() > 0 && fq[i][fq[i].size()-1].start + flen(i) > cyc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget);
    int b = 0;
    while (!all_idle() && b < budget) begin
      step();
      b++;
    end
    check("idle_wait", -1, int'(all_idle()), 1);
  endtask

  // ---------------- directed frame table ----------------
  typedef struct {
    int          inst;
    logic [8:0]  word;
    logic [11:0] bits;   // bit 0 = first slot on the line (start bit)
    int          nbits;
  } vec_t;

  vec_t vt [5];

  initial begin
    int i, L, n0, hi, zeros, got, b, bcnt;
    logic [8:0] words3 [3];

    vt[0] = '{inst: 0, word: 9'h034, bits: 12'h268, nbits: 10};  // 8N1
    vt[1] = '{inst: 1, word: 9'h055, bits: 12'h4AA, nbits: 11};  // 8E1, parity 0
    vt[2] = '{inst: 2, word: 9'h055, bits: 12'h6AA, nbits: 11};  // 8O1, parity 1
    vt[3] = '{inst: 3, word: 9'h07F, bits: 12'h3FE, nbits: 10};  // 7N2
    vt[4] = '{inst: 4, word: 9'h1FF, bits: 12'h7FE, nbits: 11};  // 9N1, CPB=2

    for (int k = 0; k < NI; k++) begin
      valid[k] = 1'b0;
      din[k] = '0;
    end
    model_reset();

    // reset values
    #12;
    for (int k = 0; k < NI; k++) begin
      check("rst_txd", k, int'(txd[k]), 1);
      check("rst_ready", k, int'(rdy[k]), 1);
      check("rst_busy", k, int'(busy[k]), 0);
      check("rst_count", k, int'(cnt[k]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven single frames
    for (int v = 0; v < 5; v++) begin
      wait_idle(200);
      i = vt[v].inst;
      L = vt[v].nbits * P_CPB[i];
      din[i] = vt[v].word;
      valid[i] = 1'b1;
      step();
      valid[i] = 1'b0;
      bcnt = int'(busy[i]);
      for (int j = 0; j < L; j++) begin
        step();
        check("vec_txd", i, int'(txd[i]), int'(vt[v].bits[j / P_CPB[i]]));
        if (busy[i]) bcnt++;
      end
      step();
      check("vec_busy_end", i, int'(busy[i]), 0);
      check("vec_txd_idle", i, int'(txd[i]), 1);
      check("vec_busy_len", i, bcnt, L + 1);
    end

    // 7N2: full stop period, then a word pushed mid-frame starts at cycle 40
    wait_idle(200);
    din[3] = 9'h07F;
    valid[3] = 1'b1;
    step();
    valid[3] = 1'b0;
    n0 = cyc;
    repeat (10) step();
    din[3] = 9'h02A;
    valid[3] = 1'b1;
    step();
    valid[3] = 1'b0;
    hi = 0;
    b = 0;
    while (cyc < n0 + 40 && b < 100) begin
      step();
      b++;
      if (cyc >= n0 + 33 && txd[3]) hi++;
    end
    check("7n2_stop_high", 3, hi, 8);
    step();
    check("7n2_next_start", 3, int'(txd[3]), 0);
    check("7n2_next_cycle", 3, cyc - n0, 41);

    // FIFO fill: six words offered on consecutive edges
    wait_idle(400);
    got = 0;
    b = 0;
    n0 = 0;
    din[0] = 9'($urandom_range(0, 255));
    valid[0] = 1'b1;
    while (got < 6 && b < 300) begin
      step();
      b++;
      if (acc[0]) begin
        got++;
        if (got == 1) n0 = cyc;
        din[0] = 9'($urandom_range(0, 255));
      end
      if (got > 0 && cyc == n0 + 4) begin
        check("fifo_full_count", 0, int'(cnt[0]), 4);
        check("fifo_full_ready", 0, int'(rdy[0]), 0);
      end
      if (got > 0 && cyc == n0 + 41) begin
        check("fifo_pop_count", 0, int'(cnt[0]), 3);
        check("fifo_pop_ready", 0, int'(rdy[0]), 1);
      end
    end
    valid[0] = 1'b0;
    check("fifo_accepted", 0, got, 6);
    check("fifo_last_accept", 0, cyc - n0, 42);

    // asynchronous reset in the middle of a data bit with two words queued
    wait_idle(600);
    words3[0] = 9'h034;
    words3[1] = 9'h0A1;
    words3[2] = 9'h0B2;
    for (int k = 0; k < 3; k++) begin
      din[0] = words3[k];
      valid[0] = 1'b1;
      step();
      if (k == 0) n0 = cyc;
    end
    valid[0] = 1'b0;
    while (cyc < n0 + 14) step();
    check("pre_rst_count", 0, int'(cnt[0]), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_txd", 0, int'(txd[0]), 1);
    check("async_rst_count", 0, int'(cnt[0]), 0);
    check("async_rst_busy", 0, int'(busy[0]), 0);
    check("async_rst_ready", 0, int'(rdy[0]), 1);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    zeros = 0;
    repeat (150) begin
      step();
      if (!txd[0]) zeros++;
    end
    check("no_residual_frames", 0, zeros, 0);

    // randomized traffic on every configuration
    repeat (2500) begin
      for (int k = 0; k < NI; k++) begin
        if (!valid[k] && $urandom_range(0, 99) < 6) begin
          valid[k] = 1'b1;
          din[k] = 9'($urandom_range(0, 511));
        end
      end
      step();
      for (int k = 0; k < NI; k++) if (acc[k]) valid[k] = 1'b0;
    end
    for (int k = 0; k < NI; k++) valid[k] = 1'b0;
    wait_idle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
